// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the memory-port arbiter: bus widths, FSM encoding
// and the latched request record.
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_WORD_WIDTH = 16;
  localparam int MARB_RETRY_W   = 3;

  // Ten states are needed (DONE/FAIL and LDONE/DDONE each drive a distinct pulse), so 4 bits.
  typedef enum logic [3:0] {
    MARB_IDLE   = 4'd0,
    MARB_SETUP  = 4'd1,
    MARB_STROBE = 4'd2,
    MARB_WAIT   = 4'd3,
    MARB_DONE   = 4'd4,
    MARB_FAIL   = 4'd5,
    MARB_LOAD   = 4'd6,
    MARB_DUMP   = 4'd7,
    MARB_LDONE  = 4'd8,
    MARB_DDONE  = 4'd9
  } marb_state_t;

  typedef struct packed {
    logic                      port;
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_WORD_WIDTH-1:0] wdata;
  } mem_req_t;

  function automatic logic marb_in_access(input marb_state_t s);
    return (s == MARB_SETUP) || (s == MARB_STROBE) || (s == MARB_WAIT);
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin pick: when both ports request, the one not named by ptr wins.
// Purely combinational; the caller owns the pointer update.
module mem_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = (&req) ? ~ptr : req[1];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Owns the MEMU control port: arbitrates two requesters, runs setup/strobe/sample with
// retries (Ack at N+4, +2 per retry), and slots ROM readback/writeback strobes between accesses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Req0,
  input  logic                      Req1,
  input  logic                      We0,
  input  logic                      We1,
  input  logic [MEM_ADDR_WIDTH-1:0] Addr0,
  input  logic [MEM_ADDR_WIDTH-1:0] Addr1,
  input  logic [MEM_WORD_WIDTH-1:0] Wdata0,
  input  logic [MEM_WORD_WIDTH-1:0] Wdata1,
  output logic                      Ack0,
  output logic                      Ack1,
  output logic                      Err0,
  output logic                      Err1,
  output logic [MEM_WORD_WIDTH-1:0] Rdata,
  input  logic                      Load_req,
  input  logic                      Dump_req,
  output logic                      Load_done,
  output logic                      Dump_done,
  output logic                      Read_sig,
  output logic                      Write_sig,
  output logic                      Mem_op_enable,
  output logic [MEM_ADDR_WIDTH-1:0] Address_in,
  output logic [MEM_WORD_WIDTH-1:0] Data_in,
  input  logic [MEM_WORD_WIDTH-1:0] Data_out,
  input  logic                      Mem_op_success,
  output logic                      Read_back_sig,
  output logic                      Write_back_sig
);

  localparam logic [MARB_RETRY_W-1:0] MAX_R = MARB_RETRY_W'(MAX_RETRIES);

  marb_state_t               state, state_nxt;
  mem_req_t                  cur, cur_nxt;
  logic [MARB_RETRY_W-1:0]   retry_cnt, retry_nxt;
  logic                      ptr, ptr_nxt;
  logic                      load_pend, load_pend_nxt;
  logic                      dump_pend, dump_pend_nxt;
  logic                      load_any, dump_any;
  logic                      grant_valid, grant_id;
  logic                      in_acc;

  logic                      ack0_nxt, ack1_nxt, err0_nxt, err1_nxt;
  logic                      load_done_nxt, dump_done_nxt;
  logic                      read_sig_nxt, write_sig_nxt, mem_op_enable_nxt;
  logic                      read_back_nxt, write_back_nxt;
  logic [MEM_WORD_WIDTH-1:0] rdata_nxt;

  mem_rr_pick u_pick (
    .req         ({Req1, Req0}),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // The request record is itself a register, so the MEMU address/data lines come straight from it.
  assign Address_in = cur.addr;
  assign Data_in    = cur.wdata;

  always_comb begin
    state_nxt     = state;
    cur_nxt       = cur;
    retry_nxt     = retry_cnt;
    ptr_nxt       = ptr;
    rdata_nxt     = Rdata;
    // A pulse arriving in the same IDLE cycle is served at once rather than a cycle late.
    load_any      = load_pend | Load_req;
    dump_any      = dump_pend | Dump_req;
    load_pend_nxt = load_any;
    dump_pend_nxt = dump_any;

    case (state)
      MARB_IDLE: begin
        if (load_any) begin
          state_nxt     = MARB_LOAD;
          load_pend_nxt = 1'b0;
        end else if (dump_any) begin
          state_nxt     = MARB_DUMP;
          dump_pend_nxt = 1'b0;
        end else if (grant_valid) begin
          cur_nxt   = grant_id ? '{port: 1'b1, we: We1, addr: Addr1, wdata: Wdata1}
                               : '{port: 1'b0, we: We0, addr: Addr0, wdata: Wdata0};
          retry_nxt = '0;
          state_nxt = MARB_SETUP;
        end
      end
      MARB_SETUP:  state_nxt = MARB_STROBE;
      MARB_STROBE: state_nxt = MARB_WAIT;
      MARB_WAIT: begin
        if (Mem_op_success) begin
          if (!cur.we) rdata_nxt = Data_out;
          state_nxt = MARB_DONE;
        end else if (retry_cnt < MAX_R) begin
          retry_nxt = retry_cnt + 1'b1;
          state_nxt = MARB_STROBE;
        end else begin
          state_nxt = MARB_FAIL;
        end
      end
      MARB_DONE, MARB_FAIL: begin
        ptr_nxt   = cur.port;
        state_nxt = MARB_IDLE;
      end
      MARB_LOAD:  state_nxt = MARB_LDONE;
      MARB_DUMP:  state_nxt = MARB_DDONE;
      MARB_LDONE: state_nxt = MARB_IDLE;
      MARB_DDONE: state_nxt = MARB_IDLE;
      default:    state_nxt = MARB_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with it.
    in_acc            = marb_in_access(state_nxt);
    read_sig_nxt      = in_acc & ~cur_nxt.we;
    write_sig_nxt     = in_acc &  cur_nxt.we;
    mem_op_enable_nxt = (state_nxt == MARB_STROBE);
    ack0_nxt          = (state_nxt == MARB_DONE) & ~cur_nxt.port;
    ack1_nxt          = (state_nxt == MARB_DONE) &  cur_nxt.port;
    err0_nxt          = (state_nxt == MARB_FAIL) & ~cur_nxt.port;
    err1_nxt          = (state_nxt == MARB_FAIL) &  cur_nxt.port;
    read_back_nxt     = (state_nxt == MARB_LOAD);
    write_back_nxt    = (state_nxt == MARB_DUMP);
    load_done_nxt     = (state_nxt == MARB_LDONE);
    dump_done_nxt     = (state_nxt == MARB_DDONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= MARB_IDLE;
      cur       <= '0;
      retry_cnt <= '0;
      ptr       <= 1'b0;
      load_pend <= 1'b0;
      dump_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      retry_cnt <= retry_nxt;
      ptr       <= ptr_nxt;
      load_pend <= load_pend_nxt;
      dump_pend <= dump_pend_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Ack0           <= 1'b0;
      Ack1           <= 1'b0;
      Err0           <= 1'b0;
      Err1           <= 1'b0;
      Rdata          <= '0;
      Load_done      <= 1'b0;
      Dump_done      <= 1'b0;
      Read_sig       <= 1'b0;
      Write_sig      <= 1'b0;
      Mem_op_enable  <= 1'b0;
      Read_back_sig  <= 1'b0;
      Write_back_sig <= 1'b0;
    end else begin
      Ack0           <= ack0_nxt;
      Ack1           <= ack1_nxt;
      Err0           <= err0_nxt;
      Err1           <= err1_nxt;
      Rdata          <= rdata_nxt;
      Load_done      <= load_done_nxt;
      Dump_done      <= dump_done_nxt;
      Read_sig       <= read_sig_nxt;
      Write_sig      <= write_sig_nxt;
      Mem_op_enable  <= mem_op_enable_nxt;
      Read_back_sig  <= read_back_nxt;
      Write_back_sig <= write_back_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized single-port accesses, checked against a memory
// image and latency rules derived from the access protocol.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int MAXR = 3;
  localparam int AW   = MEM_ADDR_WIDTH;
  localparam int DW   = MEM_WORD_WIDTH;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
  logic [AW-1:0] Addr0 = '0, Addr1 = '0;
  logic [DW-1:0] Wdata0 = '0, Wdata1 = '0;
  logic          Ack0, Ack1, Err0, Err1;
  logic [DW-1:0] Rdata;
  logic          Load_req = 1'b0, Dump_req = 1'b0, Load_done, Dump_done;
  logic          Read_sig, Write_sig, Mem_op_enable;
  logic [AW-1:0] Address_in;
  logic [DW-1:0] Data_in;
  logic [DW-1:0] Data_out = '0;
  logic          Mem_op_success = 1'b0;
  logic          Read_back_sig, Write_back_sig;

  int errors = 0;
  int checks = 0;
  int cycle_no = 0;

  logic [DW-1:0] memu    [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_rdata = '0;
  int inj_fail = 0, strobes = 0;
  int rb_cnt = 0, wb_cnt = 0, ld_cnt = 0, dd_cnt = 0, resp_cnt = 0;
  logic prev_en = 1'b0;

  mem_port_arbiter #(.MAX_RETRIES(MAXR)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
    .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1), .Rdata(Rdata),
    .Load_req(Load_req), .Dump_req(Dump_req), .Load_done(Load_done), .Dump_done(Dump_done),
    .Read_sig(Read_sig), .Write_sig(Write_sig), .Mem_op_enable(Mem_op_enable),
    .Address_in(Address_in), .Data_in(Data_in), .Data_out(Data_out),
    .Mem_op_success(Mem_op_success),
    .Read_back_sig(Read_back_sig), .Write_back_sig(Write_back_sig)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cycle_no <= cycle_no + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {5'd0, Ack0, Ack1, Err0, Err1, Load_done, Dump_done, Read_sig, Write_sig,
            Mem_op_enable, Read_back_sig, Write_back_sig, Rdata, Address_in, Data_in};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // MEMU responder and protocol invariants, evaluated mid-cycle.
  always @(negedge Clk) begin
    check("rw_exclusive", 64'(Read_sig & Write_sig), 64'd0);
    check("strobe_one_cycle", 64'(Mem_op_enable & prev_en), 64'd0);
    check("back_vs_access", 64'((Read_back_sig | Write_back_sig) & (Read_sig | Write_sig | Mem_op_enable)), 64'd0);
    prev_en = Mem_op_enable;
    if (Mem_op_enable) begin
      strobes++;
      if (inj_fail > 0) begin
        inj_fail--;
        Mem_op_success = 1'b0;
      end else begin
        Mem_op_success = 1'b1;
        if (Write_sig) memu[Address_in[7:0]] = Data_in;
        else           Data_out = memu[Address_in[7:0]];
      end
    end
    if (Read_back_sig)  rb_cnt++;
    if (Write_back_sig) wb_cnt++;
    if (Load_done)      ld_cnt++;
    if (Dump_done)      dd_cnt++;
    if (Ack0 | Ack1 | Err0 | Err1) resp_cnt++;
  end

  // One access on a single port; expected latency, response kind and strobe count
  // follow from the number of injected MEMU failures.
  task automatic run_access(input bit port, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input int nfail, input string tag);
    int t0, lat, exp_lat, exp_strobes;
    bit exp_err, seen;
    logic [3:0] resp, exp_resp;
    inj_fail = nfail;
    strobes  = 0;
    if (port) begin Req1 = 1'b1; We1 = we; Addr1 = addr; Wdata1 = wd; end
    else      begin Req0 = 1'b1; We0 = we; Addr0 = addr; Wdata0 = wd; end
    t0   = cycle_no;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      seen = Ack0 | Ack1 | Err0 | Err1;
    end
    lat  = cycle_no - t0;
    resp = {Ack0, Ack1, Err0, Err1};
    Req0 = 1'b0;
    Req1 = 1'b0;
    exp_err     = (nfail > MAXR);
    exp_lat     = exp_err ? (3 + 2 * MAXR + 1) : (4 + 2 * nfail);
    exp_strobes = exp_err ? (MAXR + 1) : (nfail + 1);
    exp_resp    = exp_err ? (port ? 4'b0001 : 4'b0010) : (port ? 4'b0100 : 4'b1000);
    if (!exp_err && !we) exp_rdata = ref_mem[addr[7:0]];
    if (!exp_err && we)  ref_mem[addr[7:0]] = wd;
    check({tag, "_resp_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_resp_kind"}, 64'(resp), 64'(exp_resp));
    check({tag, "_strobes"}, 64'(strobes), 64'(exp_strobes));
    check({tag, "_rdata"}, 64'(Rdata), 64'(exp_rdata));
    inj_fail = 0;
    tick();
    check({tag, "_quiet_after"}, 64'({Ack0, Ack1, Err0, Err1}), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n, base0, base1, base2, base3;
    int got_port [4];
    int got_cyc  [4];
    bit seen;
    for (int i = 0; i < 256; i++) begin
      memu[i]    = DW'($urandom);
      ref_mem[i] = memu[i];
    end
    for (int i = 0; i < 4; i++) begin got_port[i] = -1; got_cyc[i] = 0; end

    // Reset state
    repeat (3) tick();
    check("reset_outputs", all_out(), 64'd0);
    Reset = 1'b0;
    tick();
    check("idle_outputs", all_out(), 64'd0);

    // 1: single read of a preloaded word
    memu[8'h0F]    = 16'hF00F;
    ref_mem[8'h0F] = 16'hF00F;
    run_access(1'b0, 1'b0, 16'h000F, 16'h0000, 0, "t1_read");

    // 2: both ports held, grants alternate starting with port 1
    inj_fail = 0;
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h0001;
    Req1 = 1'b1; We1 = 1'b0; Addr1 = 16'h0002;
    t0 = cycle_no;
    n  = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (Ack0 | Ack1) begin
        got_port[n] = int'(Ack1);
        got_cyc[n]  = cycle_no;
        n++;
      end
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    exp_rdata = ref_mem[1];
    check("rr_ack_count", 64'(n), 64'd4);
    check("rr_first_latency", 64'(got_cyc[0] - t0), 64'd4);
    for (int k = 0; k < 4; k++) check("rr_grant_order", 64'(got_port[k]), 64'((k % 2 == 0) ? 1 : 0));
    for (int k = 1; k < 4; k++) check("rr_ack_spacing", 64'(got_cyc[k] - got_cyc[k-1]), 64'd5);
    check("rr_rdata", 64'(Rdata), 64'(exp_rdata));
    tick();

    // 3: MEMU always fails on port 1, then a recovery after two retries
    run_access(1'b1, 1'b0, 16'h0003, 16'h0000, 100, "t3_err");
    run_access(1'b1, 1'b0, 16'h0004, 16'h0000, 2, "t3_retry_ok");

    // 4: two Dump pulses during a port 0 write collapse into one writeback after the Ack
    base0 = wb_cnt; base1 = dd_cnt;
    Req0 = 1'b1; We0 = 1'b1; Addr0 = 16'h0020; Wdata0 = 16'hBEEF;
    t0 = cycle_no;
    tick();
    Dump_req = 1'b1; tick(); Dump_req = 1'b0;
    Dump_req = 1'b1; tick(); Dump_req = 1'b0;
    tick();
    check("t4_ack0", 64'(Ack0), 64'd1);
    check("t4_ack_latency", 64'(cycle_no - t0), 64'd4);
    check("t4_no_early_wb", 64'(wb_cnt - base0), 64'd0);
    check("t4_write_keeps_rdata", 64'(Rdata), 64'(exp_rdata));
    Req0 = 1'b0;
    ref_mem[8'h20] = 16'hBEEF;
    tick();
    check("t4_idle_no_wb", 64'(Write_back_sig), 64'd0);
    tick();
    check("t4_write_back", 64'({Write_back_sig, Dump_done}), 64'b10);
    tick();
    check("t4_dump_done", 64'({Write_back_sig, Dump_done}), 64'b01);
    repeat (3) tick();
    check("t4_wb_once", 64'(wb_cnt - base0), 64'd1);
    check("t4_done_once", 64'(dd_cnt - base1), 64'd1);

    // 5: Load and Req1 together: readback first, then port 1 reads the word written above
    base2 = rb_cnt; base3 = ld_cnt;
    Load_req = 1'b1;
    Req1 = 1'b1; We1 = 1'b0; Addr1 = 16'h0020;
    t0 = cycle_no;
    tick();
    Load_req = 1'b0;
    check("t5_read_back", 64'({Read_back_sig, Read_sig}), 64'b10);
    tick();
    check("t5_load_done", 64'(Load_done), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      seen = Ack0 | Ack1 | Err0 | Err1;
    end
    Req1 = 1'b0;
    exp_rdata = ref_mem[8'h20];
    check("t5_ack1", 64'({Ack0, Ack1, Err0, Err1}), 64'b0100);
    check("t5_ack_latency", 64'(cycle_no - t0), 64'd7);
    check("t5_rdata", 64'(Rdata), 64'(exp_rdata));
    check("t5_rb_once", 64'((rb_cnt - base2) * 16 + (ld_cnt - base3)), 64'h11);
    tick();

    // 6: reset while in WAIT aborts silently
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h000F;
    repeat (3) tick();
    check("t6_in_wait", 64'({Read_sig, Mem_op_enable}), 64'b10);
    base0 = resp_cnt;
    Reset = 1'b1;
    Req0  = 1'b0;
    tick();
    check("t6_reset_outputs", all_out(), 64'd0);
    Reset = 1'b0;
    exp_rdata = '0;
    repeat (6) tick();
    check("t6_no_resp", 64'(resp_cnt - base0), 64'd0);
    run_access(1'b0, 1'b0, 16'h000F, 16'h0000, 0, "t6_fresh");

    // Randomized single-port traffic with occasional injected failures
    for (int it = 0; it < 40; it++) begin
      int nf;
      nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 15)), DW'($urandom), nf, "rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
